level_memory: RTL and testbench
===============================

LEVEL_MEMORY -- requirements
Module: level_memory

Interface
REQ-001 SHALL have parameter DM_WORDS, default 1024, number of 32-bit data-memory words (byte address space = 4*DM_WORDS).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high; sampled only on rising clk.
REQ-004 SHALL have port: Instr_in  input  32  instruction currently in memory stage.
REQ-005 SHALL have port: judge_in  input  1  blezals condition result from execute stage.
REQ-006 SHALL have port: pc_add_4_in  input  32  PC+4 of instruction.
REQ-007 SHALL have port: pc_add_8_in  input  32  PC+8 of instruction (link value).
REQ-008 SHALL have port: ALUResult_in  input  32  ALU result / effective byte address.
REQ-009 SHALL have port: Store_data_in  input  32  rt value (already forwarded) for sw.
REQ-010 SHALL have port: WriteRegNum_in  input  5  destination register number.
REQ-011 SHALL have outputs Instr_out(32), judge_out(1), pc_add_4_out(32), pc_add_8_out(32), ALUResult_out(32), DM_data_out(32), WriteRegNum_out(5): registered MEM/WB values feeding the write-back stage.

Function
REQ-012 SHALL contain a DM_WORDS x 32 data memory indexed by word address ALUResult_in[11:2] (for DM_WORDS=1024); ALUResult_in[1:0] SHALL be ignored.
REQ-013 SHALL treat an address as in-range only when ALUResult_in[31:2] < DM_WORDS.
REQ-014 SHALL write Store_data_in to the addressed word on a rising edge only when Instr_in[31:26]==6'b101011 (sw), address in-range, and reset==0.
REQ-015 SHALL perform no memory write for any other opcode, including lw, beq, jal, j, blezals, R-type and nop (all-zero word).
REQ-016 SHALL suppress the write for out-of-range sw; memory contents unchanged.
REQ-017 SHALL read memory combinationally at the addressed word and capture it into DM_data_out on each rising edge, for every instruction; out-of-range reads SHALL capture 32'h0.
REQ-018 SHALL capture the pre-write (old) word into DM_data_out when sw and capture coincide (read-before-write).
REQ-019 SHALL make a word written by sw at edge N visible to an lw entering the stage at edge N+1 or later (one-cycle write-to-read latency, no bypass needed).
REQ-020 SHALL register Instr_in, judge_in, pc_add_4_in, pc_add_8_in, ALUResult_in, WriteRegNum_in unmodified into the corresponding *_out on every rising edge (latency exactly 1 cycle, no stall/enable).
REQ-021 SHALL not alter WriteRegNum (register-0 suppression is performed downstream).
REQ-022 SHALL keep the stage free of internal state other than the memory array and the MEM/WB registers.

Reset
REQ-023 SHALL, on a rising edge with reset==1, clear every *_out register to 0 (Instr_out=0 acts as nop, so no GRF write downstream).
REQ-024 SHALL, on that same edge, clear all DM_WORDS memory words to 32'h0.
REQ-025 SHALL give reset priority over a simultaneous sw: write discarded, word reads 0 afterwards.
REQ-026 SHALL resume normal capture on the first rising edge with reset==0; reset mid-program loses all prior stores.

Verification
REQ-027 SHALL verify: reset 1 cycle, then lw addr 0x0 -> DM_data_out=0, all other outputs match inputs one cycle later, Instr_out=0 during reset cycle.
REQ-028 SHALL verify: sw 0x12345678 to 0x10, next cycle lw 0x10 -> DM_data_out=0x12345678 after lw edge; lw 0x14 -> 0.
REQ-029 SHALL verify: sw 0xAAAA5555 to 0x13 (unaligned) -> lw 0x10 returns 0xAAAA5555; sw DM_data_out captured = old value 0.
REQ-030 SHALL verify: sw 0xDEADBEEF to 0x1000 (out of range, DM_WORDS=1024) -> no write, lw 0x0 returns prior value, lw 0x1000 returns 0.
REQ-031 SHALL verify: sw 0xCAFEF00D to 0x20 with reset=1 same edge -> after reset lw 0x20 returns 0; stores issued before reset also read 0.
REQ-032 SHALL verify: jal with pc_add_8_in=0x3008, WriteRegNum_in=31, and blezals with judge_in=1 -> pc_add_8_out=0x3008, WriteRegNum_out=31, judge_out=1 one cycle later; memory unchanged.

Source files
------------

// File: rtl/level_memory.sv
// Memory stage: word-addressed data memory plus MEM/WB pipeline registers.
// Latency 1 cycle for all outputs; no stall or backpressure, a new instruction every clock.
module level_memory #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_in,
  input  logic        judge_in,
  input  logic [31:0] pc_add_4_in,
  input  logic [31:0] pc_add_8_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] Store_data_in,
  input  logic [4:0]  WriteRegNum_in,
  output logic [31:0] Instr_out,
  output logic        judge_out,
  output logic [31:0] pc_add_4_out,
  output logic [31:0] pc_add_8_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] DM_data_out,
  output logic [4:0]  WriteRegNum_out
);

  localparam int         AW    = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic [31:0]   mem_q [DM_WORDS];
  logic          in_range;
  logic          is_sw;
  logic [AW-1:0] word_idx;
  logic [31:0]   dm_data_d;

  logic [31:0]   instr_q;
  logic          judge_q;
  logic [31:0]   pc_add_4_q;
  logic [31:0]   pc_add_8_q;
  logic [31:0]   alu_result_q;
  logic [31:0]   dm_data_q;
  logic [4:0]    write_reg_num_q;

  // Byte offset bits are dropped; high address bits only decide range, never alias.
  assign in_range = ({2'b00, ALUResult_in[31:2]} < 32'(DM_WORDS));
  assign is_sw    = (Instr_in[31:26] == OP_SW);
  assign word_idx = ALUResult_in[AW+1:2];

  always_comb begin
    dm_data_d = 32'h0;
    if (in_range) begin
      dm_data_d = mem_q[word_idx];
    end
  end

  // Reset wipes the whole array and wins over a coincident store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (is_sw && in_range) begin
      mem_q[word_idx] <= Store_data_in;
    end
  end

  // Read data is sampled from the pre-edge array, giving read-before-write on sw.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q         <= 32'h0;
      judge_q         <= 1'b0;
      pc_add_4_q      <= 32'h0;
      pc_add_8_q      <= 32'h0;
      alu_result_q    <= 32'h0;
      dm_data_q       <= 32'h0;
      write_reg_num_q <= 5'h0;
    end else begin
      instr_q         <= Instr_in;
      judge_q         <= judge_in;
      pc_add_4_q      <= pc_add_4_in;
      pc_add_8_q      <= pc_add_8_in;
      alu_result_q    <= ALUResult_in;
      dm_data_q       <= dm_data_d;
      write_reg_num_q <= WriteRegNum_in;
    end
  end

  assign Instr_out       = instr_q;
  assign judge_out       = judge_q;
  assign pc_add_4_out    = pc_add_4_q;
  assign pc_add_8_out    = pc_add_8_q;
  assign ALUResult_out   = alu_result_q;
  assign DM_data_out     = dm_data_q;
  assign WriteRegNum_out = write_reg_num_q;

  // Store_data_in is consumed only by the array; keep the lint view tidy.
  logic unused_ok;
  assign unused_ok = ^Store_data_in;

endmodule

// File: tb/tb_level_memory.sv
// Bench for level_memory: directed vectors with literal checks plus a per-cycle reference model.
module tb_level_memory;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BLZ = 6'b011111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_in, pc_add_4_in, pc_add_8_in, ALUResult_in, Store_data_in;
  logic        judge_in;
  logic [4:0]  WriteRegNum_in;
  logic [31:0] Instr_out, pc_add_4_out, pc_add_8_out, ALUResult_out, DM_data_out;
  logic        judge_out;
  logic [4:0]  WriteRegNum_out;

  int passed = 0;
  int total  = 0;

  level_memory #(.DM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .Instr_in(Instr_in), .judge_in(judge_in),
    .pc_add_4_in(pc_add_4_in), .pc_add_8_in(pc_add_8_in),
    .ALUResult_in(ALUResult_in), .Store_data_in(Store_data_in),
    .WriteRegNum_in(WriteRegNum_in),
    .Instr_out(Instr_out), .judge_out(judge_out),
    .pc_add_4_out(pc_add_4_out), .pc_add_8_out(pc_add_8_out),
    .ALUResult_out(ALUResult_out), .DM_data_out(DM_data_out),
    .WriteRegNum_out(WriteRegNum_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: sparse word array, absent entries read as zero.
  logic [31:0] ref_mem [int];
  logic [31:0] e_instr, e_pc4, e_pc8, e_alu, e_dm;
  logic        e_judge;
  logic [4:0]  e_wr;
  bit          e_vld = 0;

  always @(posedge clk) begin
    int word;
    bit ok;
    word = int'(ALUResult_in >> 2);
    ok   = (ALUResult_in >> 2) < 32'd1024;
    if (reset) begin
      {e_instr, e_pc4, e_pc8, e_alu, e_dm, e_judge, e_wr} = '0;
      ref_mem.delete();
    end else begin
      e_instr = Instr_in;  e_judge = judge_in;
      e_pc4   = pc_add_4_in; e_pc8 = pc_add_8_in;
      e_alu   = ALUResult_in; e_wr = WriteRegNum_in;
      e_dm    = (ok && ref_mem.exists(word)) ? ref_mem[word] : 32'h0;
      if (ok && Instr_in[31:26] == OP_SW) ref_mem[word] = Store_data_in;
    end
    e_vld = 1;
  end

  always @(negedge clk) begin
    if (e_vld) begin
      chk("model Instr_out",       Instr_out,              e_instr);
      chk("model judge_out",       {31'h0, judge_out},     {31'h0, e_judge});
      chk("model pc_add_4_out",    pc_add_4_out,           e_pc4);
      chk("model pc_add_8_out",    pc_add_8_out,           e_pc8);
      chk("model ALUResult_out",   ALUResult_out,          e_alu);
      chk("model DM_data_out",     DM_data_out,            e_dm);
      chk("model WriteRegNum_out", {27'h0, WriteRegNum_out}, {27'h0, e_wr});
    end
  end

  // Drive one instruction, wait for its capture edge, and leave time 1 past it.
  task automatic step(input logic rst, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic jdg,
                      input logic [31:0] pc8, input logic [4:0] wr);
    reset          = rst;
    Instr_in       = {op, 26'h0000123};
    ALUResult_in   = addr;
    Store_data_in  = sdata;
    judge_in       = jdg;
    pc_add_4_in    = pc8 - 32'd4;
    pc_add_8_in    = pc8;
    WriteRegNum_in = wr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, OP_LW, 32'h0, 32'h0, 1'b0, 32'h3008, 5'd3);
    chk("reset Instr_out", Instr_out, 32'h0);
    chk("reset DM_data_out", DM_data_out, 32'h0);
    chk("reset pc_add_8_out", pc_add_8_out, 32'h0);

    step(1'b0, OP_LW, 32'h0, 32'h0, 1'b0, 32'h3010, 5'd4);
    chk("lw0 DM_data_out", DM_data_out, 32'h0);
    chk("lw0 Instr_out", Instr_out, {OP_LW, 26'h0000123});
    chk("lw0 pc_add_4_out", pc_add_4_out, 32'h300c);

    step(1'b0, OP_SW, 32'h13, 32'hAAAA5555, 1'b0, 32'h3014, 5'd0);
    chk("sw unaligned old data", DM_data_out, 32'h0);
    step(1'b0, OP_LW, 32'h10, 32'h0, 1'b0, 32'h3018, 5'd5);
    chk("lw 0x10 after unaligned sw", DM_data_out, 32'hAAAA5555);

    step(1'b0, OP_SW, 32'h10, 32'h12345678, 1'b0, 32'h301c, 5'd0);
    chk("sw read-before-write", DM_data_out, 32'hAAAA5555);
    step(1'b0, OP_LW, 32'h10, 32'h0, 1'b0, 32'h3020, 5'd6);
    chk("lw 0x10 next cycle", DM_data_out, 32'h12345678);
    step(1'b0, OP_LW, 32'h14, 32'h0, 1'b0, 32'h3024, 5'd7);
    chk("lw 0x14 untouched", DM_data_out, 32'h0);

    step(1'b0, OP_SW, 32'h0, 32'h11111111, 1'b0, 32'h3028, 5'd0);
    step(1'b0, OP_SW, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h302c, 5'd0);
    chk("sw out of range capture", DM_data_out, 32'h0);
    step(1'b0, OP_LW, 32'h0, 32'h0, 1'b0, 32'h3030, 5'd8);
    chk("lw 0x0 after oor sw", DM_data_out, 32'h11111111);
    step(1'b0, OP_LW, 32'h1000, 32'h0, 1'b0, 32'h3034, 5'd8);
    chk("lw 0x1000 out of range", DM_data_out, 32'h0);

    step(1'b0, OP_JAL, 32'h0, 32'h5555AAAA, 1'b0, 32'h3008, 5'd31);
    chk("jal pc_add_8_out", pc_add_8_out, 32'h3008);
    chk("jal WriteRegNum_out", {27'h0, WriteRegNum_out}, 32'd31);
    step(1'b0, OP_BLZ, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h3040, 5'd31);
    chk("blezals judge_out", {31'h0, judge_out}, 32'h1);
    step(1'b0, OP_LW, 32'h10, 32'h0, 1'b0, 32'h3044, 5'd9);
    chk("mem unchanged after jal/blezals", DM_data_out, 32'h12345678);

    step(1'b1, OP_SW, 32'h20, 32'hCAFEF00D, 1'b0, 32'h3048, 5'd0);
    chk("sw under reset Instr_out", Instr_out, 32'h0);
    step(1'b0, OP_LW, 32'h20, 32'h0, 1'b0, 32'h304c, 5'd10);
    chk("lw 0x20 after reset", DM_data_out, 32'h0);
    step(1'b0, OP_LW, 32'h10, 32'h0, 1'b0, 32'h3050, 5'd11);
    chk("lw 0x10 store lost", DM_data_out, 32'h0);
    step(1'b0, OP_LW, 32'h0, 32'h0, 1'b0, 32'h3054, 5'd12);
    chk("lw 0x0 store lost", DM_data_out, 32'h0);

    // Mixed traffic on a small address window, checked by the model only.
    for (int i = 0; i < 80; i++) begin
      logic [5:0]  op;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0, 1:    op = OP_SW;
        2:       op = OP_LW;
        default: op = 6'($urandom);
      endcase
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
      step($urandom_range(0, 19) == 0, op, a, $urandom, 1'($urandom),
           $urandom, 5'($urandom));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
